// File: rtl/fsk_mod.sv
// rtl/fsk_mod.sv - binary FSK modulator, one byte per frame, LSB first
// Optional preamble (8 symbols of 8'h55) enabled by defining FSK_MOD_PREAMBLE_EN.
module fsk_mod #(
  parameter int SYM_LEN = 16,
  parameter int HALF1   = 2,
  parameter int HALF0   = 8
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       sig_rf,
  output logic       trans_enable,
  output logic       bit_strobe
);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_GUARD} state_t;

  localparam logic [4:0] SYM_LAST = 5'(SYM_LEN - 1);
  localparam logic [4:0] SYM_PEN  = 5'(SYM_LEN - 2);
  localparam logic [4:0] TGL1     = 5'(HALF1 - 1);
  localparam logic [4:0] TGL0     = 5'(HALF0 - 1);

  state_t     state_q;
  logic [7:0] shreg_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [4:0] sym_cnt_q, sym_cnt_d;
  logic [4:0] tgl_cnt_q, tgl_cnt_d;
  logic       sig_rf_q, trans_enable_q, bit_strobe_q;
  logic       sym_end, tgl_hit, last_bit;
`ifdef FSK_MOD_PREAMBLE_EN
  logic [7:0] data_q;
`endif

  always_comb begin
    sym_end   = (sym_cnt_q == SYM_LAST);
    tgl_hit   = (tgl_cnt_q == (shreg_q[0] ? TGL1 : TGL0));
    last_bit  = (bit_cnt_q == 3'd7);
    sym_cnt_d = sym_end ? 5'd0 : sym_cnt_q + 5'd1;
    // Toggle phase restarts at every symbol, but the line level carries over.
    tgl_cnt_d = (sym_end || tgl_hit) ? 5'd0 : tgl_cnt_q + 5'd1;
    bit_cnt_d = last_bit ? 3'd0 : bit_cnt_q + 3'd1;
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      shreg_q        <= '0;
      bit_cnt_q      <= '0;
      sym_cnt_q      <= '0;
      tgl_cnt_q      <= '0;
      sig_rf_q       <= 1'b0;
      trans_enable_q <= 1'b0;
      bit_strobe_q   <= 1'b0;
`ifdef FSK_MOD_PREAMBLE_EN
      data_q         <= '0;
`endif
    end else begin
      bit_strobe_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (data_valid) begin
            bit_cnt_q      <= '0;
            sym_cnt_q      <= '0;
            tgl_cnt_q      <= '0;
            trans_enable_q <= 1'b1;
`ifdef FSK_MOD_PREAMBLE_EN
            data_q  <= data_in;
            shreg_q <= 8'h55;
            state_q <= S_PRE;
`else
            shreg_q <= data_in;
            state_q <= S_DATA;
`endif
          end
        end
`ifdef FSK_MOD_PREAMBLE_EN
        S_PRE,
`endif
        S_DATA: begin
          sym_cnt_q <= sym_cnt_d;
          tgl_cnt_q <= tgl_cnt_d;
          if (tgl_hit) sig_rf_q <= ~sig_rf_q;
          // Registered strobe: set one cycle early so it lands on the last symbol cycle.
          if (state_q == S_DATA && sym_cnt_q == SYM_PEN) bit_strobe_q <= 1'b1;
          if (sym_end) begin
            shreg_q   <= shreg_q >> 1;
            bit_cnt_q <= bit_cnt_d;
            if (last_bit) begin
`ifdef FSK_MOD_PREAMBLE_EN
              if (state_q == S_DATA) begin
                state_q <= S_GUARD;
              end else begin
                shreg_q <= data_q;
                state_q <= S_DATA;
              end
`else
              state_q <= S_GUARD;
`endif
            end
          end
        end
        S_GUARD: begin
          sym_cnt_q <= sym_cnt_d;
          if (sym_end) begin
            state_q        <= S_IDLE;
            trans_enable_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data_ready   = (state_q == S_IDLE);
  assign sig_rf       = sig_rf_q;
  assign trans_enable = trans_enable_q;
  assign bit_strobe   = bit_strobe_q;

endmodule

// File: doc/fsk_mod.md
# fsk_mod

Binary FSK modulator, the transmit side of the team's 16-cycle-per-symbol FSK link. It accepts one byte per frame over a valid/ready handshake and serialises it LSB first. For each bit it emits a square wave on `sig_rf`: fast toggling for 1, slow toggling for 0. The far-end `fsk_dem` threshold (fewer than 6 edges per window means 0) decodes this correctly. `trans_enable` is high for the whole frame and feeds the local receiver's `trans_enable` input to hold it in reset during half-duplex transmit.

## Interface
- `SYM_LEN`, 16: sysclk cycles per symbol; a power of two, ≤32.
- `HALF1`, 2: half-period in cycles for bit 1; 8 toggles per symbol.
- `HALF0`, 8: half-period in cycles for bit 0; 2 toggles per symbol. `HALF1` < `HALF0`; both divide `SYM_LEN`.
- `sysclk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `data_in`  in  8  byte to send; captured on accept.
- `data_valid`  in  1  byte available.
- `data_ready`  out  1  high only in IDLE.
- `sig_rf`  out  1  modulated line, registered.
- `trans_enable`  out  1  high while a frame is in progress, registered.
- `bit_strobe`  out  1  one-cycle pulse on the last cycle of each data symbol, registered.

## Operation
- **States:** IDLE → (PREAMBLE) → DATA → GUARD → IDLE.
- **IDLE**
  - `sig_rf` is held at its current level; `trans_enable` = 0; `data_ready` = 1.
  - Accept occurs when `data_valid` && `data_ready` on a rising edge: `data_in` loads the shift register, the bit counter clears, `sym_cnt` clears, and the FSM moves to DATA (or PREAMBLE when enabled).
- **DATA**
  - Exactly 8 symbols, LSB first. The current bit is `shreg[0]`.
  - `sym_cnt` counts 0..`SYM_LEN`-1 and wraps to 0 at each symbol end. At the wrap, `shreg` shifts right and the bit counter increments. After bit 7 the FSM goes to GUARD.
  - Toggle counter `tgl_cnt` clears at every symbol start. `sig_rf` inverts when `tgl_cnt` == HALF−1, and `tgl_cnt` then restarts at 0. HALF is `HALF1` or `HALF0` according to the current bit.
  - Phase is continuous: `sig_rf` is never forced to a level at symbol boundaries.
- **GUARD**
  - One symbol with `sig_rf` frozen and `trans_enable` still 1, so the far end sees 0 edges (decodes as 0) and the last window settles. Then the FSM returns to IDLE.
- **Ignored input:** `data_valid` asserted outside IDLE is ignored; the input byte is not latched.
- **Reset**
  - Reset values: `sig_rf` = 0, `trans_enable` = 0, `bit_strobe` = 0, `data_ready` = 1, state = IDLE, all counters = 0.
  - Reset mid-frame aborts immediately, with no GUARD symbol.
- **Counter widths:** `sym_cnt` and `tgl_cnt` are 5-bit and the bit counter is 3-bit. Wrap is by explicit compare, never by overflow.

## Timing
- **Accept:** accept at edge T. `trans_enable` rises at T+1, and the first symbol occupies cycles T+1 .. T+`SYM_LEN`.
- **First toggle:** for bit 1 the first `sig_rf` toggle is visible at T+`HALF1`; for bit 0, at T+`HALF0`.
- **Frame length:** `trans_enable` stays high for 9·`SYM_LEN` cycles (144 at default), or 17·`SYM_LEN` (272) with the preamble.
- **Back-to-back:** `data_ready` returns at the first IDLE cycle, so the minimum accept-to-accept spacing is 9·`SYM_LEN`+1 cycles.
- **`bit_strobe`:** pulses on cycle `sym_cnt` == `SYM_LEN`-1 of DATA symbols only, 8 pulses per frame.

## Configuration
- **`FSK_MOD_PREAMBLE_EN` defined:** PREAMBLE state sends 8 symbols of fixed pattern 8'h55, LSB first (1,0,1,0,…), before DATA.
  - `bit_strobe` is silent during the preamble.
  - GUARD is unchanged.
- **`FSK_MOD_PREAMBLE_EN` undefined:** the PREAMBLE state and its logic are absent; accept goes straight to DATA.

## Test plan
- **Reset:** assert `reset`=0 mid-frame (during symbol 3) → same cycle `sig_rf`=0, `trans_enable`=0, `data_ready`=1. After release, IDLE with no toggles for 50 cycles.
- **All ones:** send 8'hFF → 8 symbols of exactly 8 `sig_rf` edges per 16-cycle window, then 0 edges in GUARD. `trans_enable` is high for 144 cycles, with 8 `bit_strobe` pulses.
- **All zeros:** send 8'h00 → every 16-cycle window has exactly 2 edges, with toggles at symbol cycles 7 and 15.
- **Mixed pattern:** send 8'hA5 → per-window edge counts 8,2,8,2,2,8,2,8. The same 16-cycle windows counted from T+1 through an `fsk_dem` instance (with its `trans_enable` tied low) give `sig_reb` 1,0,1,0,0,1,0,1.
- **Handshake:** hold `data_valid`=1 with 8'h3C then 8'hC3 changing during a frame → only 8'h3C sent first. 8'hC3 is accepted exactly 145 cycles after the first accept; the mid-frame value is not latched.
- **Preamble:** with `FSK_MOD_PREAMBLE_EN`, send 8'h00 → window edge counts 8,2,8,2,8,2,8,2 then 2×8, then GUARD. `trans_enable` is high for 272 cycles.
